// File: rtl/fir_pkg.sv
// Shared types and default coefficients for the fir_decim_mac decimating FIR.
package fir_pkg;

   // Sequencer states: waiting for samples, running a MAC pass, holding a result.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      HOLD = 2'd2
   } fir_state_e;

   // Power-up coefficient for tap idx of a num_taps filter. The 8-tap set is the
   // tuned low-pass; any other length falls back to a symmetric triangle.
   function automatic int fir_default_coeff(input int num_taps, input int idx);
      int lo;
      int result;
      result = 0;
      if (num_taps == 8) begin
         case (idx)
            0, 7:    result = 10;
            1, 6:    result = 32;
            2, 5:    result = 84;
            default: result = 127;
         endcase
      end else begin
         lo     = (idx < (num_taps - 1 - idx)) ? idx : (num_taps - 1 - idx);
         result = lo + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/fir_coeff_bank.sv
// Coefficient storage for fir_decim_mac.
// FIR_COEFF_LOAD_EN defined: shadow bank written through coeff_we/coeff_addr/
// coeff_data, copied to the active bank on coeff_commit; the active bank is
// snapshotted into a working set on latch (MAC start) so a running pass never
// sees a commit. Undefined: the read port returns the package defaults and all
// load inputs are ignored.
module fir_coeff_bank
   import fir_pkg::*;
#(
   parameter int NUM_TAPS    = 8,
   parameter int COEFF_WIDTH = 8,
   parameter int AW          = $clog2(NUM_TAPS)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          coeff_we,
   input  logic [AW-1:0]                 coeff_addr,
   input  logic signed [COEFF_WIDTH-1:0] coeff_data,
   input  logic                          coeff_commit,
   input  logic                          latch,
   input  logic [AW-1:0]                 rd_addr,
   output logic signed [COEFF_WIDTH-1:0] rd_coeff
);

`ifdef FIR_COEFF_LOAD_EN
   logic signed [COEFF_WIDTH-1:0] dflt     [NUM_TAPS];
   logic signed [COEFF_WIDTH-1:0] shadow_q [NUM_TAPS];
   logic signed [COEFF_WIDTH-1:0] shadow_d [NUM_TAPS];
   logic signed [COEFF_WIDTH-1:0] active_q [NUM_TAPS];
   logic signed [COEFF_WIDTH-1:0] active_d [NUM_TAPS];
   logic signed [COEFF_WIDTH-1:0] work_q   [NUM_TAPS];
   logic signed [COEFF_WIDTH-1:0] work_d   [NUM_TAPS];

   for (genvar gi = 0; gi < NUM_TAPS; gi++) begin : g_dflt
      assign dflt[gi] = COEFF_WIDTH'(fir_default_coeff(NUM_TAPS, gi));
   end

   // Shadow writes, commit to active, and snapshot of active at MAC start.
   always_comb begin
      shadow_d = shadow_q;
      active_d = active_q;
      work_d   = work_q;
      for (int i = 0; i < NUM_TAPS; i++) begin
         if (coeff_we && (coeff_addr == AW'(i))) begin
            shadow_d[i] = coeff_data;
         end
      end
      if (coeff_commit) begin
         active_d = shadow_q;
      end
      if (latch) begin
         work_d = active_q;
      end
   end

   // All three banks return to the default set on reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         shadow_q <= dflt;
         active_q <= dflt;
         work_q   <= dflt;
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
         work_q   <= work_d;
      end
   end

   assign rd_coeff = work_q[rd_addr];
`else
   logic unused_inputs;
   assign unused_inputs = ^{clk, reset, coeff_we, coeff_addr, coeff_data,
                            coeff_commit, latch};

   assign rd_coeff = COEFF_WIDTH'(fir_default_coeff(NUM_TAPS, int'(rd_addr)));
`endif

endmodule

// File: rtl/fir_decim_mac.sv
// Time-multiplexed decimating FIR: one MAC per clock, one result per DECIMATE
// accepted samples, valid/ready output with a one-deep pending sample buffer.
// Runtime coefficient loading is compiled in with FIR_COEFF_LOAD_EN.
module fir_decim_mac
   import fir_pkg::*;
#(
   parameter int NUM_TAPS    = 8,
   parameter int COEFF_WIDTH = 8,
   parameter int DATA_WIDTH  = 16,
   parameter int OUT_WIDTH   = 32,
   parameter int DECIMATE    = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          sample,
   input  logic signed [DATA_WIDTH-1:0]  data_in,
   input  logic                          coeff_we,
   input  logic [$clog2(NUM_TAPS)-1:0]   coeff_addr,
   input  logic signed [COEFF_WIDTH-1:0] coeff_data,
   input  logic                          coeff_commit,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic signed [OUT_WIDTH-1:0]   data_out,
   output logic                          done,
   output logic                          busy,
   output logic                          overrun
);

   localparam int AW  = $clog2(NUM_TAPS);
   localparam int TCW = $clog2(NUM_TAPS + 1);
   localparam int DCW = (DECIMATE > 1) ? $clog2(DECIMATE) : 1;
   localparam int PW  = COEFF_WIDTH + DATA_WIDTH;
   // Tap counter runs 0..NUM_TAPS-1 issuing products, then one drain cycle
   // at NUM_TAPS where the last registered product is folded into acc.
   localparam logic [TCW-1:0] TAP_DRAIN  = TCW'(NUM_TAPS);
   localparam logic [DCW-1:0] DECIM_LAST = DCW'(DECIMATE - 1);

   fir_state_e                   state_q, state_d;
   logic [TCW-1:0]               tap_cnt_q, tap_cnt_d;
   logic [DCW-1:0]               decim_cnt_q, decim_cnt_d;
   logic signed [DATA_WIDTH-1:0] x_q [NUM_TAPS];
   logic signed [DATA_WIDTH-1:0] x_d [NUM_TAPS];
   logic signed [PW-1:0]         prod_q, prod_d;
   logic signed [OUT_WIDTH-1:0]  acc_q, acc_d;
   logic                         pend_valid_q, pend_valid_d;
   logic signed [DATA_WIDTH-1:0] pend_data_q, pend_data_d;
   logic signed [OUT_WIDTH-1:0]  data_out_q, data_out_d;
   logic                         out_valid_q, out_valid_d;
   logic                         done_q, done_d;
   logic                         overrun_q, overrun_d;

   logic                         take;
   logic signed [DATA_WIDTH-1:0] take_data;
   logic                         load;
   logic signed [OUT_WIDTH-1:0]  load_val;
   logic                         coeff_latch;
   logic [AW-1:0]                tap_idx;
   logic signed [COEFF_WIDTH-1:0] coeff_rd;
   logic signed [PW-1:0]         mult;
   logic signed [OUT_WIDTH-1:0]  prod_ext;

   assign tap_idx  = tap_cnt_q[AW-1:0];
   assign mult     = PW'(coeff_rd) * PW'(x_q[tap_idx]);
   assign prod_ext = {{(OUT_WIDTH - PW){prod_q[PW-1]}}, prod_q};

   fir_coeff_bank #(
      .NUM_TAPS    (NUM_TAPS),
      .COEFF_WIDTH (COEFF_WIDTH),
      .AW          (AW)
   ) u_coeff_bank (
      .clk          (clk),
      .reset        (reset),
      .coeff_we     (coeff_we),
      .coeff_addr   (coeff_addr),
      .coeff_data   (coeff_data),
      .coeff_commit (coeff_commit),
      .latch        (coeff_latch),
      .rd_addr      (tap_idx),
      .rd_coeff     (coeff_rd)
   );

   // Sequencer: sample intake, MAC pass, result hand-off and pending buffer.
   always_comb begin
      state_d      = state_q;
      tap_cnt_d    = tap_cnt_q;
      decim_cnt_d  = decim_cnt_q;
      x_d          = x_q;
      prod_d       = prod_q;
      acc_d        = acc_q;
      pend_valid_d = pend_valid_q;
      pend_data_d  = pend_data_q;
      data_out_d   = data_out_q;
      out_valid_d  = out_valid_q;
      overrun_d    = overrun_q;
      take         = 1'b0;
      take_data    = data_in;
      load         = 1'b0;
      load_val     = acc_q;
      coeff_latch  = 1'b0;

      // Consumer takes the current result; a same-edge load below re-asserts.
      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            // A buffered sample always goes first; a fresh strobe refills the buffer.
            if (pend_valid_q) begin
               take         = 1'b1;
               take_data    = pend_data_q;
               pend_valid_d = sample;
               if (sample) begin
                  pend_data_d = data_in;
               end
            end else if (sample) begin
               take = 1'b1;
            end

            if (take) begin
               for (int k = NUM_TAPS - 1; k > 0; k--) begin
                  x_d[k] = x_q[k-1];
               end
               x_d[0] = take_data;
               if (decim_cnt_q == DECIM_LAST) begin
                  decim_cnt_d = '0;
                  coeff_latch = 1'b1;
                  acc_d       = '0;
                  prod_d      = '0;
                  tap_cnt_d   = '0;
                  state_d     = MAC;
               end else begin
                  decim_cnt_d = decim_cnt_q + DCW'(1);
               end
            end
         end

         MAC, HOLD: begin
            if (sample) begin
               if (pend_valid_q) begin
                  overrun_d = 1'b1;
               end else begin
                  pend_valid_d = 1'b1;
                  pend_data_d  = data_in;
               end
            end

            if (state_q == MAC) begin
               // Product of the previous tap is accumulated while the next is formed.
               acc_d = acc_q + prod_ext;
               if (tap_cnt_q == TAP_DRAIN) begin
                  if (out_valid_q && !out_ready) begin
                     state_d = HOLD;
                  end else begin
                     load     = 1'b1;
                     load_val = acc_d;
                     state_d  = IDLE;
                  end
               end else begin
                  prod_d    = mult;
                  tap_cnt_d = tap_cnt_q + TCW'(1);
               end
            end else begin
               if (!out_valid_q || out_ready) begin
                  load     = 1'b1;
                  load_val = acc_q;
                  state_d  = IDLE;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      if (load) begin
         data_out_d  = load_val;
         out_valid_d = 1'b1;
      end
      done_d = load;
   end

   // State and datapath registers; reset abandons any pass without output.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= IDLE;
         tap_cnt_q    <= '0;
         decim_cnt_q  <= '0;
         for (int k = 0; k < NUM_TAPS; k++) begin
            x_q[k] <= '0;
         end
         prod_q       <= '0;
         acc_q        <= '0;
         pend_valid_q <= 1'b0;
         pend_data_q  <= '0;
         data_out_q   <= '0;
         out_valid_q  <= 1'b0;
         done_q       <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         tap_cnt_q    <= tap_cnt_d;
         decim_cnt_q  <= decim_cnt_d;
         x_q          <= x_d;
         prod_q       <= prod_d;
         acc_q        <= acc_d;
         pend_valid_q <= pend_valid_d;
         pend_data_q  <= pend_data_d;
         data_out_q   <= data_out_d;
         out_valid_q  <= out_valid_d;
         done_q       <= done_d;
         overrun_q    <= overrun_d;
      end
   end

   assign data_out  = data_out_q;
   assign out_valid = out_valid_q;
   assign done      = done_q;
   assign overrun   = overrun_q;
   assign busy      = (state_q != IDLE);

endmodule
